// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, two write-back ports,
// same-cycle write-back bypass and a per-register busy scoreboard for RAW stalls.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic                       we_0,
    input  logic [ADDR_W-1:0]          wr_addr_0,
    input  logic [DATA_W-1:0]          wr_data_0,
    input  logic                       we_1,
    input  logic [ADDR_W-1:0]          wr_addr_1,
    input  logic [DATA_W-1:0]          wr_data_1,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_reg [NREG];
    logic [NREG-1:0]   busy_reg;
    logic [NREG-1:0]   busy_next;
    logic [CNT_W-1:0]  busy_cnt_reg;
    logic [CNT_W-1:0]  busy_cnt_next;

    // Qualified write-back enables: address 0 never accepts a write.
    logic wb_vld_0;
    logic wb_vld_1;

    assign wb_vld_0 = we_0 && (wr_addr_0 != '0);
    assign wb_vld_1 = we_1 && (wr_addr_1 != '0);

    // Storage: one flop row per register. Row 0 never has a write enable,
    // so it holds its reset value of zero forever.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_row
        logic hit_0;
        logic hit_1;

        assign hit_0 = wb_vld_0 && (wr_addr_0 == ADDR_W'(gi)) && (gi != 0);
        assign hit_1 = wb_vld_1 && (wr_addr_1 == ADDR_W'(gi)) && (gi != 0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_reg[gi] <= '0;
            end else if (hit_1) begin
                mem_reg[gi] <= wr_data_1;
            end else if (hit_0) begin
                mem_reg[gi] <= wr_data_0;
            end
        end
    end

    // Scoreboard next state: a fresh issue outranks a completing write-back,
    // and flush keeps only the producer issuing in the same cycle.
    always_comb begin
        busy_next = busy_reg;
        for (int r = 1; r < NREG; r++) begin
            logic set_b;
            logic clr_b;
            set_b = iss_valid && (iss_addr == ADDR_W'(r));
            clr_b = (wb_vld_0 && (wr_addr_0 == ADDR_W'(r))) ||
                    (wb_vld_1 && (wr_addr_1 == ADDR_W'(r)));
            if (flush) begin
                busy_next[r] = set_b;
            end else begin
                busy_next[r] = set_b | (busy_reg[r] & ~clr_b);
            end
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_cnt_next = busy_cnt_next + CNT_W'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    // Read ports: bypass from write-back port 1, then port 0, then storage.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              byp_1;
        logic              byp_0;
        logic [DATA_W-1:0] data_k;
        logic              ready_k;

        assign addr  = rd_addr[gi*ADDR_W +: ADDR_W];
        assign byp_1 = wb_vld_1 && (wr_addr_1 == addr);
        assign byp_0 = wb_vld_0 && (wr_addr_0 == addr);

        always_comb begin
            data_k  = '0;
            ready_k = 1'b1;
            // Bypass would otherwise leak write-back data during reset.
            if (rst_n && re[gi]) begin
                if (byp_1) begin
                    data_k = wr_data_1;
                end else if (byp_0) begin
                    data_k = wr_data_0;
                end else begin
                    data_k = mem_reg[addr];
                end
                ready_k = !busy_reg[addr] || byp_0 || byp_1;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data_k;
        assign rd_ready[gi]                 = ready_k;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: inputs change on the falling edge, outputs are
// checked 1 ns later; registered effects are checked one falling edge later.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic                     we_0;
    logic [ADDR_W-1:0]        wr_addr_0;
    logic [DATA_W-1:0]        wr_data_0;
    logic                     we_1;
    logic [ADDR_W-1:0]        wr_addr_1;
    logic [DATA_W-1:0]        wr_data_1;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .re        (re),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .we_0      (we_0),
        .wr_addr_0 (wr_addr_0),
        .wr_data_0 (wr_data_0),
        .we_1      (we_1),
        .wr_addr_1 (wr_addr_1),
        .wr_data_1 (wr_data_1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        re        = '0;
        rd_addr   = '0;
        we_0      = 1'b0;
        wr_addr_0 = '0;
        wr_data_0 = '0;
        we_1      = 1'b0;
        wr_addr_1 = '0;
        wr_data_1 = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        flush     = 1'b0;
    endtask

    task automatic rd_set(input int k, input logic [ADDR_W-1:0] a);
        re[k] = 1'b1;
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [31:0] rdat(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    // Advance to the next falling edge with quiet inputs.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy_cnt", 32'(busy_cnt), 32'd0);
        chk("reset_ready", 32'(rd_ready), 32'h3);
        rst_n = 1'b1;

        // 1. every register reads zero and ready after reset
        for (int a = 0; a < 32; a++) begin
            step();
            rd_set(0, ADDR_W'(a));
            rd_set(1, ADDR_W'(31 - a));
            #1;
            chk($sformatf("rst_rd0_x%0d", a), rdat(0), 32'd0);
            chk($sformatf("rst_rd1_x%0d", 31 - a), rdat(1), 32'd0);
            chk($sformatf("rst_rdy_x%0d", a), 32'(rd_ready), 32'h3);
        end
        step();
        we_0 = 1'b1; wr_addr_0 = 5'd0; wr_data_0 = 32'hDEADBEEF;
        rd_set(0, 5'd0);
        #1;
        chk("x0_bypass", rdat(0), 32'd0);
        step();
        rd_set(0, 5'd0);
        #1;
        chk("x0_stored", rdat(0), 32'd0);

        // 2. bypass then storage
        step();
        we_0 = 1'b1; wr_addr_0 = 5'd5; wr_data_0 = 32'h12345678;
        rd_set(0, 5'd5);
        #1;
        chk("x5_bypass", rdat(0), 32'h12345678);
        step();
        rd_set(0, 5'd5);
        #1;
        chk("x5_stored", rdat(0), 32'h12345678);

        // 3. dual write, port 1 wins
        step();
        we_0 = 1'b1; wr_addr_0 = 5'd7; wr_data_0 = 32'h1;
        we_1 = 1'b1; wr_addr_1 = 5'd7; wr_data_1 = 32'h2;
        rd_set(1, 5'd7);
        #1;
        chk("x7_bypass", rdat(1), 32'h2);
        step();
        rd_set(1, 5'd7);
        #1;
        chk("x7_stored", rdat(1), 32'h2);

        // 4. issue then write-back
        step();
        iss_valid = 1'b1; iss_addr = 5'd3;
        rd_set(0, 5'd3);
        #1;
        chk("x3_ready_issue_cycle", 32'(rd_ready[0]), 32'd1);
        step();
        rd_set(0, 5'd3);
        #1;
        chk("x3_not_ready", 32'(rd_ready[0]), 32'd0);
        chk("x3_busy_cnt", 32'(busy_cnt), 32'd1);
        we_0 = 1'b1; wr_addr_0 = 5'd3; wr_data_0 = 32'hAA;
        #1;
        chk("x3_wb_ready", 32'(rd_ready[0]), 32'd1);
        chk("x3_wb_data", rdat(0), 32'hAA);
        step();
        rd_set(0, 5'd3);
        #1;
        chk("x3_busy_cnt_clr", 32'(busy_cnt), 32'd0);
        chk("x3_ready_after", 32'(rd_ready[0]), 32'd1);
        chk("x3_stored", rdat(0), 32'hAA);

        // 5. issue and write-back to the same register: issue wins
        step();
        iss_valid = 1'b1; iss_addr = 5'd9;
        we_1 = 1'b1; wr_addr_1 = 5'd9; wr_data_1 = 32'h55;
        step();
        rd_set(0, 5'd9);
        #1;
        chk("x9_data", rdat(0), 32'h55);
        chk("x9_not_ready", 32'(rd_ready[0]), 32'd0);
        chk("x9_busy_cnt", 32'(busy_cnt), 32'd1);
        // retire x9 so the next step starts from an empty scoreboard
        we_0 = 1'b1; wr_addr_0 = 5'd9; wr_data_0 = 32'h55;
        step();
        #1;
        chk("x9_retired_cnt", 32'(busy_cnt), 32'd0);

        // 6. fill x1..x4, flush with a concurrent issue to x6
        for (int a = 1; a <= 4; a++) begin
            step();
            iss_valid = 1'b1; iss_addr = ADDR_W'(a);
        end
        step();
        #1;
        chk("four_busy_cnt", 32'(busy_cnt), 32'd4);
        flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd6;
        step();
        rd_set(0, 5'd6);
        rd_set(1, 5'd2);
        #1;
        chk("flush_busy_cnt", 32'(busy_cnt), 32'd1);
        chk("flush_ready", 32'(rd_ready), 32'h2);
        // x0 never becomes busy; disabled port is ready even on a busy register
        iss_valid = 1'b1; iss_addr = 5'd0;
        step();
        rd_set(0, 5'd0);
        rd_addr[ADDR_W +: ADDR_W] = 5'd6;
        #1;
        chk("x0_never_busy_cnt", 32'(busy_cnt), 32'd1);
        chk("re_off_ready", 32'(rd_ready), 32'h3);
        chk("re_off_data", rdat(1), 32'd0);

        // mid-sequence asynchronous reset with a bypass pending
        step();
        rd_set(0, 5'd6);
        rd_set(1, 5'd5);
        we_1 = 1'b1; wr_addr_1 = 5'd5; wr_data_1 = 32'hCAFEF00D;
        #1;
        chk("pre_rst_bypass", rdat(1), 32'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", 32'(busy_cnt), 32'd0);
        chk("async_rst_ready", 32'(rd_ready), 32'h3);
        chk("async_rst_rd0", rdat(0), 32'd0);
        chk("async_rst_rd1", rdat(1), 32'd0);
        step();
        rst_n = 1'b1;
        rd_set(0, 5'd5);
        rd_set(1, 5'd7);
        #1;
        chk("post_rst_x5", rdat(0), 32'd0);
        chk("post_rst_x7", rdat(1), 32'd0);
        chk("post_rst_ready", 32'(rd_ready), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file with a configurable number of read ports, two write-back ports and an integrated per-register scoreboard. Sits between decode/issue and write-back in the pipeline. It supplies operands with same-cycle write-back bypass, and reports per-operand readiness so issue can stall on RAW hazards without an external scoreboard.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous reset, active-low
re  in  NUM_RD  read enable, one bit per read port
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rd_ready  out  NUM_RD  operand k is valid (not pending)
we_0  in  1  write-back port 0 enable
wr_addr_0  in  ADDR_W  write-back port 0 address
wr_data_0  in  DATA_W  write-back port 0 data
we_1  in  1  write-back port 1 enable (higher priority)
wr_addr_1  in  ADDR_W  write-back port 1 address
wr_data_1  in  DATA_W  write-back port 1 data
iss_valid  in  1  an instruction with a destination register issues this cycle
iss_addr  in  ADDR_W  destination register of the issuing instruction
flush  in  1  clear all pending (busy) marks
busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. While rst_n is low, rd_data = 0 and rd_ready = all ones.
- Register 0 is hardwired zero: writes are ignored, it is never marked busy, and reads return 0 with ready = 1.
- Reads are combinational. Per port k:
  - re[k] = 0: rd_data = 0 and rd_ready = 1.
  - re[k] = 1 with a hit on port 1 (we_1 and wr_addr_1 == addr != 0): data = wr_data_1.
  - Otherwise, a hit on port 0: data = wr_data_0.
  - Otherwise: data = stored value.
  - rd_ready = !busy[addr] OR a write-back hit this cycle.
- Writes occur on the rising edge. If both ports target the same nonzero address, port 1's data is stored and port 0 is dropped.
- Scoreboard, per register r != 0, evaluated each edge:
  - set = iss_valid && iss_addr == r
  - clr = (we_0 && wr_addr_0 == r) || (we_1 && wr_addr_1 == r)
  - flush = 1: busy[r] <= set. Flush clears everything except a same-cycle issue.
  - Otherwise: set wins over clr (the new producer is pending), so busy[r] <= set | (busy[r] & !clr).
- Issuing to an already-busy register is legal; it stays busy. Only one outstanding producer per register is tracked, so the first write-back clears it.
- busy_cnt equals the population count of the busy bits after each edge, registered. Range 0..NREG-1.
- Latency: a write is visible through bypass in the same cycle and from storage on the next cycle. An issue makes rd_ready drop in the cycle after iss_valid.

Test Plan:
1. Reset, then read x0..x31 on all ports -> rd_data = 0, rd_ready = 1, busy_cnt = 0; write x0 = 0xDEADBEEF -> x0 still reads 0.
2. we_0 writes x5 = 0x12345678 while port 0 reads x5 the same cycle -> rd_data = 0x12345678 combinationally; on the next cycle it is read from storage with the same value.
3. Both ports write x7 (port 0 = 0x1, port 1 = 0x2) in the same cycle -> bypass shows 0x2 and x7 stores 0x2.
4. Issue x3, then read x3 the next cycle -> rd_ready = 0, busy_cnt = 1. Write-back x3 = 0xAA -> rd_ready = 1 with data 0xAA in that cycle; busy_cnt = 0 after the edge.
5. Same cycle: iss_valid to x9 and we_1 to x9 -> x9 stores the data, busy[9] = 1 after the edge, busy_cnt = 1.
6. Mark x1..x4 busy (busy_cnt = 4), then assert flush with iss_valid to x6 -> only x6 busy, busy_cnt = 1. Pulse rst_n low mid-sequence -> all outputs return to reset values immediately.
